// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline: bubble instruction, IF state
// encoding, register-field slice positions and the fetch payload.
package riscv_pipe_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;

    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_MSB = 24;
    localparam int unsigned RS2_LSB = 20;

    localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        DRAIN
    } if_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_word_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: write-enable load, flush-to-bubble (flush wins),
// asynchronous active-low reset.
module if_id_reg
    import riscv_pipe_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INS = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              flush,
    input  fetch_word_t       d,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc4,
    output logic [XLEN-1:0]   ins,
    output logic              valid
);

    // A bubble leaves the pc fields untouched so downstream debug keeps context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            pc4   <= '0;
            ins   <= BUBBLE_INS;
            valid <= 1'b0;
        end else if (flush) begin
            ins   <= BUBBLE_INS;
            valid <= 1'b0;
        end else if (we) begin
            pc    <= d.pc;
            pc4   <= d.pc + XLEN'(4);
            ins   <= d.ins;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/valid handshake, and feeds the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = riscv_pipe_pkg::NOP_INS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_write,
    input  logic        IF_ID_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_pc4,
    output logic [31:0] IF_ID_ins,
    output logic        IF_ID_valid,
    output logic [4:0]  IF_ID_rs1,
    output logic [4:0]  IF_ID_rs2
);

    import riscv_pipe_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    if_state_t       state;
    if_state_t       state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    fetch_word_t     hold_q;
    fetch_word_t     hold_nxt;
    logic            stall;
    logic            idr_we;
    logic            idr_flush;
    fetch_word_t     idr_d;

    // Either hazard signal stalls the whole stage.
    assign stall     = ~PC_write | ~IF_ID_write;
    assign imem_addr = pc;

    // Next-state, PC and IF/ID control; a redirect overrides everything.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        hold_nxt  = hold_q;
        idr_we    = 1'b0;
        idr_flush = 1'b0;
        idr_d     = '{pc: pc, ins: imem_rdata};

        if (branch_taken) begin
            pc_nxt    = branch_target & ALIGN_MASK;
            idr_flush = 1'b1;
            hold_nxt  = '0;
            case (state)
                // An unanswered request must still be absorbed before refetching.
                FETCH, DRAIN: state_nxt = imem_valid ? FETCH : DRAIN;
                default:      state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                BOOT: state_nxt = FETCH;
                FETCH: begin
                    if (imem_valid) begin
                        if (stall) begin
                            hold_nxt  = '{pc: pc, ins: imem_rdata};
                            state_nxt = HOLD;
                        end else begin
                            idr_we = 1'b1;
                            pc_nxt = pc + XLEN'(4);
                        end
                    end else if (!stall) begin
                        idr_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        idr_we    = 1'b1;
                        idr_d     = hold_q;
                        pc_nxt    = pc + XLEN'(4);
                        state_nxt = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_valid) state_nxt = FETCH;
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC & ALIGN_MASK;
            hold_q   <= '0;
            imem_req <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            hold_q   <= hold_nxt;
            imem_req <= (state_nxt == FETCH);
        end
    end

    if_id_reg #(
        .BUBBLE_INS (NOP_INS)
    ) u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (idr_we),
        .flush (idr_flush),
        .d     (idr_d),
        .pc    (IF_ID_pc),
        .pc4   (IF_ID_pc4),
        .ins   (IF_ID_ins),
        .valid (IF_ID_valid)
    );

    assign IF_ID_rs1 = IF_ID_ins[RS1_MSB:RS1_LSB];
    assign IF_ID_rs2 = IF_ID_ins[RS2_MSB:RS2_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory returns 0xC0DE0000 | addr for every word.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        PC_write;
    logic        IF_ID_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_pc4;
    logic [31:0] IF_ID_ins;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;

    int n_chk  = 0;
    int n_fail = 0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INS  (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC_write      (PC_write),
        .IF_ID_write   (IF_ID_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_pc4     (IF_ID_pc4),
        .IF_ID_ins     (IF_ID_ins),
        .IF_ID_valid   (IF_ID_valid),
        .IF_ID_rs1     (IF_ID_rs1),
        .IF_ID_rs2     (IF_ID_rs2)
    );

    assign imem_rdata = 32'hC0DE_0000 | imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   32'(imem_req),    32'h0);
        check({tag, "_addr"},  imem_addr,        32'h0);
        check({tag, "_pc"},    IF_ID_pc,         32'h0);
        check({tag, "_pc4"},   IF_ID_pc4,        32'h0);
        check({tag, "_ins"},   IF_ID_ins,        32'h0000_0013);
        check({tag, "_valid"}, 32'(IF_ID_valid), 32'h0);
    endtask

    initial begin
        rst_n         = 1'b1;
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_valid    = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");

        // Release reset between edges; first request appears after one edge.
        #3 rst_n = 1'b1;
        check("boot_req", 32'(imem_req), 32'h0);
        tick();
        check("req_rise", 32'(imem_req), 32'h1);
        check("req_addr0", imem_addr, 32'h0);
        check("boot_ifid_valid", 32'(IF_ID_valid), 32'h0);

        // Zero-wait stream
        tick();
        check("s0_pc", IF_ID_pc, 32'h0);
        check("s0_pc4", IF_ID_pc4, 32'h4);
        check("s0_ins", IF_ID_ins, 32'hC0DE_0000);
        check("s0_valid", 32'(IF_ID_valid), 32'h1);
        check("s0_rs1", 32'(IF_ID_rs1), 32'd28);
        check("s0_rs2", 32'(IF_ID_rs2), 32'd13);
        check("s0_addr", imem_addr, 32'h4);
        tick();
        check("s1_pc", IF_ID_pc, 32'h4);
        check("s1_valid", 32'(IF_ID_valid), 32'h1);

        // Stall while the response for pc=8 is arriving
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        tick();
        check("h0_req", 32'(imem_req), 32'h0);
        check("h0_pc", IF_ID_pc, 32'h4);
        check("h0_addr", imem_addr, 32'h8);
        tick();
        check("h1_req", 32'(imem_req), 32'h0);
        check("h1_pc", IF_ID_pc, 32'h4);
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        tick();
        check("h2_pc", IF_ID_pc, 32'h8);
        check("h2_ins", IF_ID_ins, 32'hC0DE_0008);
        check("h2_valid", 32'(IF_ID_valid), 32'h1);
        check("h2_req", 32'(imem_req), 32'h1);
        check("h2_addr", imem_addr, 32'hC);
        tick();
        check("h3_pc", IF_ID_pc, 32'hC);
        check("h3_addr", imem_addr, 32'h10);

        // Response delayed three cycles at pc=0x10
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("w_addr", imem_addr, 32'h10);
            check("w_req", 32'(imem_req), 32'h1);
            check("w_valid", 32'(IF_ID_valid), 32'h0);
            check("w_ins", IF_ID_ins, 32'h0000_0013);
            check("w_pc", IF_ID_pc, 32'hC);
        end
        imem_valid = 1'b1;
        tick();
        check("w_done_pc", IF_ID_pc, 32'h10);
        check("w_done_ins", IF_ID_ins, 32'hC0DE_0010);
        check("w_done_valid", 32'(IF_ID_valid), 32'h1);

        // Redirect with a response outstanding -> drain
        imem_valid    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        tick();
        branch_taken = 1'b0;
        check("d0_valid", 32'(IF_ID_valid), 32'h0);
        check("d0_ins", IF_ID_ins, 32'h0000_0013);
        check("d0_req", 32'(imem_req), 32'h0);
        check("d0_addr", imem_addr, 32'h100);
        tick();
        check("d1_req", 32'(imem_req), 32'h0);
        check("d1_valid", 32'(IF_ID_valid), 32'h0);
        imem_valid = 1'b1;
        tick();
        check("d2_req", 32'(imem_req), 32'h1);
        check("d2_valid", 32'(IF_ID_valid), 32'h0);
        check("d2_addr", imem_addr, 32'h100);
        tick();
        check("d3_pc", IF_ID_pc, 32'h100);
        check("d3_ins", IF_ID_ins, 32'hC0DE_0100);
        check("d3_valid", 32'(IF_ID_valid), 32'h1);

        // Redirect coincident with a response and a stall: flush wins
        PC_write      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        tick();
        branch_taken = 1'b0;
        PC_write     = 1'b1;
        check("f0_valid", 32'(IF_ID_valid), 32'h0);
        check("f0_ins", IF_ID_ins, 32'h0000_0013);
        check("f0_addr", imem_addr, 32'h200);
        check("f0_req", 32'(imem_req), 32'h1);
        tick();
        check("f1_pc", IF_ID_pc, 32'h200);
        check("f1_ins", IF_ID_ins, 32'hC0DE_0200);
        check("f1_valid", 32'(IF_ID_valid), 32'h1);

        // IF_ID_write alone stalls; async reset lands mid-HOLD
        IF_ID_write = 1'b0;
        tick();
        check("r0_req", 32'(imem_req), 32'h0);
        check("r0_pc", IF_ID_pc, 32'h200);
        check("r0_addr", imem_addr, 32'h204);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        IF_ID_write = 1'b1;
        #1 rst_n = 1'b1;
        check("r1_req", 32'(imem_req), 32'h0);
        tick();
        check("r2_req", 32'(imem_req), 32'h1);
        check("r2_addr", imem_addr, 32'h0);
        check("r2_valid", 32'(IF_ID_valid), 32'h0);
        tick();
        check("r3_pc", IF_ID_pc, 32'h0);
        check("r3_ins", IF_ID_ins, 32'hC0DE_0000);
        check("r3_valid", 32'(IF_ID_valid), 32'h1);

        // PC wrap at the top of the address space; target low bits masked
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        tick();
        branch_taken = 1'b0;
        check("x0_addr", imem_addr, 32'hFFFF_FFFC);
        check("x0_valid", 32'(IF_ID_valid), 32'h0);
        tick();
        check("x1_pc", IF_ID_pc, 32'hFFFF_FFFC);
        check("x1_pc4", IF_ID_pc4, 32'h0);
        check("x1_ins", IF_ID_ins, 32'hFFFF_FFFC);
        check("x1_addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
